// File: rtl/mem_stage.sv
// mem_stage: EX->MEM pipeline stage performing one word load/store per instruction.
// Optional MEM_MISALIGN_CHECK_EN: trap misaligned LDW/STW with ISA_EXP_MISS_ALIGN.

`ifndef WORD_DATA_BUS
`define WORD_DATA_BUS 32
`endif
`ifndef WORD_ADDR_BUS
`define WORD_ADDR_BUS 30
`endif
`ifndef MEM_OP_BUS
`define MEM_OP_BUS 2
`endif
`ifndef CTRL_OP_BUS
`define CTRL_OP_BUS 2
`endif
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 5
`endif
`ifndef ISA_EXP_BUS
`define ISA_EXP_BUS 3
`endif
`ifndef ISA_EXP_NO_EXP
`define ISA_EXP_NO_EXP 3'h0
`endif
`ifndef ISA_EXP_MISS_ALIGN
`define ISA_EXP_MISS_ALIGN 3'h4
`endif
`ifndef MEM_OP_LDW
`define MEM_OP_LDW 2'h1
`endif
`ifndef MEM_OP_STW
`define MEM_OP_STW 2'h2
`endif

module mem_stage (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic                      IntDetect,
    input  logic [`WORD_ADDR_BUS-1:0] EXPC,
    input  logic                      EXEn,
    input  logic                      EXBrFlag,
    input  logic [`CTRL_OP_BUS-1:0]   EXCtrlOp,
    input  logic [`REG_ADDR_BUS-1:0]  EXDstAddr,
    input  logic                      EXGPRWE_,
    input  logic [`ISA_EXP_BUS-1:0]   EXExpCode,
    input  logic [`MEM_OP_BUS-1:0]    EXMemOp,
    input  logic [`WORD_DATA_BUS-1:0] EXMemWrData,
    input  logic [`WORD_DATA_BUS-1:0] EXOut,
    output logic [`WORD_ADDR_BUS-1:0] MEMPC,
    output logic                      MEMEn,
    output logic                      MEMBrFlag,
    output logic [`CTRL_OP_BUS-1:0]   MEMCtrlOp,
    output logic [`REG_ADDR_BUS-1:0]  MEMDstAddr,
    output logic                      MEMGPRWE_,
    output logic [`ISA_EXP_BUS-1:0]   MEMExpCode,
    output logic [`WORD_DATA_BUS-1:0] MEMOut,
    output logic [`WORD_DATA_BUS-1:0] MEMFwdData,
    output logic                      MemBusy,
    output logic                      BusAs_,
    output logic                      BusRw,
    output logic [`WORD_ADDR_BUS-1:0] BusAddr,
    output logic [`WORD_DATA_BUS-1:0] BusWrData,
    input  logic                      BusRdy_,
    input  logic [`WORD_DATA_BUS-1:0] BusRdData
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                      state_q, state_d;
    logic [`WORD_DATA_BUS-1:0]   buf_q, buf_d;

    logic [`WORD_ADDR_BUS-1:0]   pc_q, pc_d;
    logic                        en_q, en_d;
    logic                        br_q, br_d;
    logic [`CTRL_OP_BUS-1:0]     ctrl_q, ctrl_d;
    logic [`REG_ADDR_BUS-1:0]    dst_q, dst_d;
    logic                        gwe_q, gwe_d;
    logic [`ISA_EXP_BUS-1:0]     exp_q, exp_d;
    logic [`WORD_DATA_BUS-1:0]   out_q, out_d;

    logic is_mem, misalign, req, done, ldw;
    logic hold_mem, bubble;

    // Decode whether this instruction drives a bus cycle now
    always_comb begin
        ldw    = (EXMemOp == `MEM_OP_LDW);
        is_mem = EXEn && (ldw || EXMemOp == `MEM_OP_STW) &&
                 (EXExpCode == `ISA_EXP_NO_EXP);
`ifdef MEM_MISALIGN_CHECK_EN
        misalign = is_mem && (EXOut[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        req      = reset_ && is_mem && !misalign && !Flush &&
                   (state_q == IDLE);
        done     = req && !BusRdy_;
        bubble   = Flush || IntDetect;
        hold_mem = Stall || (req && BusRdy_);
    end

    // FSM state and read-data hold buffer
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

    // Next state: park completed data while the pipe is stalled elsewhere
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                if (done && Stall && !IntDetect) begin
                    state_d = HOLD;
                    buf_d   = BusRdData;
                end
            end
            HOLD: begin
                if (bubble) begin
                    state_d = IDLE;
                    buf_d   = '0;
                end else if (!Stall) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Bus strobes and stall request
    always_comb begin
        BusAs_    = 1'b1;
        BusRw     = 1'b1;
        BusAddr   = '0;
        BusWrData = '0;
        MemBusy   = 1'b0;
        if (req) begin
            BusAs_  = 1'b0;
            BusRw   = ldw;
            BusAddr = EXOut[`WORD_DATA_BUS-1:2];
            MemBusy = BusRdy_;
            if (!ldw) BusWrData = EXMemWrData;
        end
    end

    // Result seen by forwarding and written into MEMOut
    always_comb begin
        MEMFwdData = EXOut;
        unique case (1'b1)
            (state_q == HOLD) && ldw: MEMFwdData = buf_q;
            done && ldw:              MEMFwdData = BusRdData;
            default: ;
        endcase
    end

    // MEM/WB register next state: bubble > hold > load
    always_comb begin
        pc_d   = pc_q;
        en_d   = en_q;
        br_d   = br_q;
        ctrl_d = ctrl_q;
        dst_d  = dst_q;
        gwe_d  = gwe_q;
        exp_d  = exp_q;
        out_d  = out_q;
        if (bubble) begin
            pc_d   = '0;
            en_d   = 1'b0;
            br_d   = 1'b0;
            ctrl_d = '0;
            dst_d  = '0;
            gwe_d  = 1'b1;
            exp_d  = `ISA_EXP_NO_EXP;
            out_d  = '0;
        end else if (!hold_mem) begin
            pc_d   = EXPC;
            en_d   = EXEn;
            br_d   = EXBrFlag;
            ctrl_d = EXCtrlOp;
            dst_d  = EXDstAddr;
            gwe_d  = EXGPRWE_;
            exp_d  = EXExpCode;
            out_d  = MEMFwdData;
            if (misalign) begin
                exp_d = `ISA_EXP_MISS_ALIGN;
                gwe_d = 1'b1;
            end
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk) begin
        if (!reset_) begin
            pc_q   <= '0;
            en_q   <= 1'b0;
            br_q   <= 1'b0;
            ctrl_q <= '0;
            dst_q  <= '0;
            gwe_q  <= 1'b1;
            exp_q  <= `ISA_EXP_NO_EXP;
            out_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            en_q   <= en_d;
            br_q   <= br_d;
            ctrl_q <= ctrl_d;
            dst_q  <= dst_d;
            gwe_q  <= gwe_d;
            exp_q  <= exp_d;
            out_q  <= out_d;
        end
    end

    assign MEMPC      = pc_q;
    assign MEMEn      = en_q;
    assign MEMBrFlag  = br_q;
    assign MEMCtrlOp  = ctrl_q;
    assign MEMDstAddr = dst_q;
    assign MEMGPRWE_  = gwe_q;
    assign MEMExpCode = exp_q;
    assign MEMOut     = out_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage.
// Expected MEM/WB records are queued at issue and matched as they retire.

module tb_mem_stage;

    localparam logic [1:0] NOP = 2'd0;
    localparam logic [1:0] LDW = 2'd1;
    localparam logic [1:0] STW = 2'd2;
    localparam logic [2:0] MISS = 3'h4;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] out;
        logic        gwe;
        logic [2:0]  ex;
        logic [4:0]  dst;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        IntDetect = 1'b0;
    logic [29:0] EXPC = '0;
    logic        EXEn = 1'b0;
    logic        EXBrFlag = 1'b0;
    logic [1:0]  EXCtrlOp = '0;
    logic [4:0]  EXDstAddr = '0;
    logic        EXGPRWE_ = 1'b1;
    logic [2:0]  EXExpCode = '0;
    logic [1:0]  EXMemOp = '0;
    logic [31:0] EXMemWrData = '0;
    logic [31:0] EXOut = '0;
    logic        BusRdy_ = 1'b1;
    logic [31:0] BusRdData = '0;

    logic [29:0] MEMPC;
    logic        MEMEn;
    logic        MEMBrFlag;
    logic [1:0]  MEMCtrlOp;
    logic [4:0]  MEMDstAddr;
    logic        MEMGPRWE_;
    logic [2:0]  MEMExpCode;
    logic [31:0] MEMOut;
    logic [31:0] MEMFwdData;
    logic        MemBusy;
    logic        BusAs_;
    logic        BusRw;
    logic [29:0] BusAddr;
    logic [31:0] BusWrData;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [29:0] last_pc = '0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset_(reset_), .Stall(Stall), .Flush(Flush),
        .IntDetect(IntDetect), .EXPC(EXPC), .EXEn(EXEn),
        .EXBrFlag(EXBrFlag), .EXCtrlOp(EXCtrlOp), .EXDstAddr(EXDstAddr),
        .EXGPRWE_(EXGPRWE_), .EXExpCode(EXExpCode), .EXMemOp(EXMemOp),
        .EXMemWrData(EXMemWrData), .EXOut(EXOut), .MEMPC(MEMPC),
        .MEMEn(MEMEn), .MEMBrFlag(MEMBrFlag), .MEMCtrlOp(MEMCtrlOp),
        .MEMDstAddr(MEMDstAddr), .MEMGPRWE_(MEMGPRWE_),
        .MEMExpCode(MEMExpCode), .MEMOut(MEMOut), .MEMFwdData(MEMFwdData),
        .MemBusy(MemBusy), .BusAs_(BusAs_), .BusRw(BusRw),
        .BusAddr(BusAddr), .BusWrData(BusWrData), .BusRdy_(BusRdy_),
        .BusRdData(BusRdData)
    );

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, want);
        end
    endtask

    task automatic push(input logic [29:0] pc, input logic [31:0] out,
                        input logic gwe, input logic [2:0] ex);
        exp_t e;
        e.pc  = pc;
        e.out = out;
        e.gwe = gwe;
        e.ex  = ex;
        e.dst = pc[4:0];
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        EXEn = 1'b0; EXPC = '0; EXMemOp = NOP; EXExpCode = '0;
        EXGPRWE_ = 1'b1; BusRdy_ = 1'b1; Stall = 1'b0;
        Flush = 1'b0; IntDetect = 1'b0;
    endtask

    task automatic setex(input logic [1:0] op, input logic [29:0] pc,
                         input logic [31:0] out, input logic [31:0] wd);
        EXEn = 1'b1; EXPC = pc; EXMemOp = op; EXOut = out;
        EXMemWrData = wd; EXDstAddr = pc[4:0];
        EXGPRWE_ = (op == STW); EXExpCode = '0;
    endtask

    task automatic run(input logic [1:0] op, input logic [29:0] pc,
                       input logic [31:0] out, input logic [31:0] wd,
                       input logic [31:0] rd, input int waits);
        logic m;
        m = (op == LDW) || (op == STW);
        setex(op, pc, out, wd);
        push(pc, (op == LDW) ? rd : out, op == STW, 3'h0);
        for (int k = 0; k <= waits; k++) begin
            BusRdy_   = (k != waits);
            BusRdData = (k == waits) ? rd : ~rd;
            @(negedge clk);
            check("as", 32'(BusAs_), 32'(!m));
            check("busy", 32'(MemBusy), 32'(m && (k < waits)));
            if (m) begin
                check("addr", 32'(BusAddr), 32'(out[31:2]));
                check("rw", 32'(BusRw), 32'(op == LDW));
                if (op == STW) check("wdata", BusWrData, wd);
                if (op == LDW && k == waits)
                    check("fwd_ld", MEMFwdData, rd);
            end else begin
                check("fwd_alu", MEMFwdData, out);
            end
            step();
        end
    endtask

    always @(negedge clk) begin
        if (MEMEn === 1'b1 && MEMPC !== last_pc) begin
            if (sb.size() == 0) begin
                check("sb_extra", 32'(MEMPC), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_pc", 32'(MEMPC), 32'(mon_e.pc));
                check("sb_out", MEMOut, mon_e.out);
                check("sb_gwe", 32'(MEMGPRWE_), 32'(mon_e.gwe));
                check("sb_exp", 32'(MEMExpCode), 32'(mon_e.ex));
                check("sb_dst", 32'(MEMDstAddr), 32'(mon_e.dst));
            end
        end
        last_pc <= MEMPC;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", 32'(MEMPC), 32'h0);
        check("rst_en", 32'(MEMEn), 32'h0);
        check("rst_gwe", 32'(MEMGPRWE_), 32'h1);
        check("rst_exp", 32'(MEMExpCode), 32'h0);
        check("rst_out", MEMOut, 32'h0);
        check("rst_ctrl", 32'(MEMCtrlOp), 32'h0);
        check("rst_as", 32'(BusAs_), 32'h1);
        check("rst_rw", 32'(BusRw), 32'h1);
        check("rst_addr", 32'(BusAddr), 32'h0);
        check("rst_wd", BusWrData, 32'h0);
        check("rst_busy", 32'(MemBusy), 32'h0);
        reset_ = 1'b1;

        run(LDW, 30'h11, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0);
        check("zw_out", MEMOut, 32'hDEAD_BEEF);
        check("zw_en", 32'(MEMEn), 32'h1);

        run(STW, 30'h12, 32'h20, 32'h1234_5678, 32'h0, 3);
        check("st_out", MEMOut, 32'h20);
        run(NOP, 30'h13, 32'hCAFE_0001, 32'h0, 32'h0, 0);

        setex(LDW, 30'h40, 32'h44, 32'h0);
        push(30'h40, 32'hA5A5_A5A5, 1'b0, 3'h0);
        Stall = 1'b1; BusRdy_ = 1'b0; BusRdData = 32'hA5A5_A5A5;
        @(negedge clk);
        check("hd_as0", 32'(BusAs_), 32'h0);
        step();
        BusRdy_ = 1'b1; BusRdData = 32'h0;
        @(negedge clk);
        check("hd_as1", 32'(BusAs_), 32'h1);
        check("hd_busy", 32'(MemBusy), 32'h0);
        check("hd_keep", 32'(MEMPC), 32'h13);
        step();
        Stall = 1'b0;
        @(negedge clk);
        check("hd_as2", 32'(BusAs_), 32'h1);
        step();
        check("hd_out", MEMOut, 32'hA5A5_A5A5);
        idle();

        setex(LDW, 30'h30, 32'h0000_1002, 32'h0);
        BusRdy_ = 1'b0; BusRdData = 32'h1111_1111;
`ifdef MEM_MISALIGN_CHECK_EN
        push(30'h30, 32'h0000_1002, 1'b1, MISS);
        @(negedge clk);
        check("ma_as", 32'(BusAs_), 32'h1);
`else
        push(30'h30, 32'h1111_1111, 1'b0, 3'h0);
        @(negedge clk);
        check("ma_as", 32'(BusAs_), 32'h0);
        check("ma_addr", 32'(BusAddr), 32'h400);
`endif
        step();
        idle();

        setex(LDW, 30'h31, 32'h100, 32'h0);
        EXExpCode = 3'h3; BusRdy_ = 1'b0;
        push(30'h31, 32'h100, 1'b0, 3'h3);
        @(negedge clk);
        check("ex_as", 32'(BusAs_), 32'h1);
        step();
        idle();

        setex(LDW, 30'h50, 32'h80, 32'h0);
        @(negedge clk);
        check("fl_as0", 32'(BusAs_), 32'h0);
        check("fl_busy0", 32'(MemBusy), 32'h1);
        step();
        Flush = 1'b1; BusRdy_ = 1'b0; BusRdData = 32'h5555_5555;
        @(negedge clk);
        check("fl_as1", 32'(BusAs_), 32'h1);
        check("fl_busy1", 32'(MemBusy), 32'h0);
        step();
        check("fl_en", 32'(MEMEn), 32'h0);
        check("fl_gwe", 32'(MEMGPRWE_), 32'h1);
        idle();

        setex(LDW, 30'h60, 32'h84, 32'h0);
        Stall = 1'b1; BusRdy_ = 1'b0; BusRdData = 32'h7777_7777;
        step();
        BusRdy_ = 1'b1; Flush = 1'b1;
        @(negedge clk);
        check("fh_as", 32'(BusAs_), 32'h1);
        step();
        check("fh_en", 32'(MEMEn), 32'h0);
        idle();
        run(LDW, 30'h61, 32'h88, 32'h0, 32'h0BAD_F00D, 1);

        for (int i = 0; i < 8; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 2));
            run(op, 30'h100 + 30'(i), $urandom & 32'hFFFF_FFFC,
                $urandom, $urandom,
                (op == NOP) ? 0 : int'($urandom_range(0, 2)));
        end
        idle();

        setex(LDW, 30'h70, 32'h90, 32'h0);
        @(negedge clk);
        check("rm_as0", 32'(BusAs_), 32'h0);
        step();
        reset_ = 1'b0;
        @(negedge clk);
        check("rm_as1", 32'(BusAs_), 32'h1);
        step();
        check("rm_en", 32'(MEMEn), 32'h0);
        check("rm_pc", 32'(MEMPC), 32'h0);
        reset_ = 1'b1;
        idle();
        run(LDW, 30'h200, 32'h400, 32'h0, 32'h1357_9BDF, 0);

        idle();
        step();
        step();
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
